// File: rtl/wash_program_sequencer_if.sv
// Command/sensor and actuator bundle between the appliance controller and the wash sequencer.
// The master side drives commands and sensor levels; the sequencer (slave) drives actuators and status.
interface wash_program_sequencer_if;
    logic       start;
    logic       abort;
    logic       door_close;
    logic       water_full;
    logic       water_empty;
    logic       door_lock;
    logic       fill_valve;
    logic       detergent_valve;
    logic       drain_pump;
    logic       motor_on;
    logic       spin_hi;
    logic       done;
    logic       fault;
    logic [3:0] state;

    modport master (
        output start, abort, door_close, water_full, water_empty,
        input  door_lock, fill_valve, detergent_valve, drain_pump,
               motor_on, spin_hi, done, fault, state
    );

    modport slave (
        input  start, abort, door_close, water_full, water_empty,
        output door_lock, fill_valve, detergent_valve, drain_pump,
               motor_on, spin_hi, done, fault, state
    );
endinterface

// File: rtl/wash_program_sequencer.sv
// Timed Moore sequencer: lock -> fill -> detergent -> wash -> drain -> (rinse passes) -> spin -> done,
// with fill/drain timeouts, door-open and abort handling forcing FAULT or ABORT_DRAIN.
module wash_program_sequencer #(
    parameter int CNT_W         = 8,
    parameter int FILL_TIMEOUT  = 16,
    parameter int DET_CYCLES    = 4,
    parameter int WASH_CYCLES   = 32,
    parameter int DRAIN_TIMEOUT = 16,
    parameter int SPIN_CYCLES   = 24,
    parameter int RINSES        = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    wash_program_sequencer_if.slave     bus
);

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_LOCK        = 4'd1,
        S_FILL        = 4'd2,
        S_DET         = 4'd3,
        S_WASH        = 4'd4,
        S_DRAIN       = 4'd5,
        S_SPIN        = 4'd6,
        S_DONE        = 4'd7,
        S_FAULT       = 4'd8,
        S_ABORT_DRAIN = 4'd9
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q;
    logic [2:0]       rinse_q, rinse_d;
    logic             in_program;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            rinse_q <= '0;
        end else begin
            state_q <= state_d;
            rinse_q <= rinse_d;
            timer_q <= (state_d != state_q) ? '0 : timer_q + 1'b1;
        end
    end

    // Door and abort supervision only applies while the program is actively running.
    assign in_program = (state_q == S_LOCK) || (state_q == S_FILL) || (state_q == S_DET) ||
                        (state_q == S_WASH) || (state_q == S_DRAIN) || (state_q == S_SPIN);

    always_comb begin
        state_d = state_q;
        rinse_d = rinse_q;
        if (in_program && !bus.door_close) begin
            state_d = S_FAULT;
        end else if (in_program && bus.abort) begin
            state_d = S_ABORT_DRAIN;
        end else begin
            case (state_q)
                S_IDLE:  if (bus.start && bus.door_close) state_d = S_LOCK;
                S_LOCK:  state_d = S_FILL;
                // A sensor edge coinciding with the last allowed cycle still counts as success.
                S_FILL: begin
                    if (bus.water_full)
                        state_d = (rinse_q == 3'd0) ? S_DET : S_WASH;
                    else if (timer_q == CNT_W'(FILL_TIMEOUT - 1))
                        state_d = S_FAULT;
                end
                S_DET:   if (timer_q == CNT_W'(DET_CYCLES - 1)) state_d = S_WASH;
                S_WASH:  if (timer_q == CNT_W'(WASH_CYCLES - 1)) state_d = S_DRAIN;
                S_DRAIN: begin
                    if (bus.water_empty) begin
                        if (rinse_q < 3'(RINSES)) begin
                            state_d = S_FILL;
                            rinse_d = rinse_q + 3'd1;
                        end else begin
                            state_d = S_SPIN;
                        end
                    end else if (timer_q == CNT_W'(DRAIN_TIMEOUT - 1)) begin
                        state_d = S_FAULT;
                    end
                end
                S_SPIN:  if (timer_q == CNT_W'(SPIN_CYCLES - 1)) state_d = S_DONE;
                S_DONE:  if (!bus.start) state_d = S_IDLE;
                S_FAULT: if (bus.abort) state_d = S_IDLE;
                S_ABORT_DRAIN: begin
                    if (bus.water_empty)
                        state_d = S_IDLE;
                    else if (timer_q == CNT_W'(DRAIN_TIMEOUT - 1))
                        state_d = S_FAULT;
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (state_d == S_IDLE) rinse_d = 3'd0;
    end

    always_comb begin
        bus.door_lock       = 1'b0;
        bus.fill_valve      = 1'b0;
        bus.detergent_valve = 1'b0;
        bus.drain_pump      = 1'b0;
        bus.motor_on        = 1'b0;
        bus.spin_hi         = 1'b0;
        bus.done            = 1'b0;
        bus.fault           = 1'b0;
        bus.state           = state_q;
        case (state_q)
            S_LOCK:  bus.door_lock = 1'b1;
            S_FILL:  begin bus.door_lock = 1'b1; bus.fill_valve = 1'b1; end
            S_DET:   begin bus.door_lock = 1'b1; bus.detergent_valve = 1'b1; end
            S_WASH:  begin bus.door_lock = 1'b1; bus.motor_on = 1'b1; end
            S_DRAIN: begin bus.door_lock = 1'b1; bus.drain_pump = 1'b1; end
            S_SPIN: begin
                bus.door_lock  = 1'b1;
                bus.drain_pump = 1'b1;
                bus.motor_on   = 1'b1;
                bus.spin_hi    = 1'b1;
            end
            S_DONE:        bus.done = 1'b1;
            S_ABORT_DRAIN: begin bus.door_lock = 1'b1; bus.drain_pump = 1'b1; end
            // Keep the door latched and pump running until the drum is confirmed empty.
            S_FAULT: begin
                bus.fault      = 1'b1;
                bus.drain_pump = !bus.water_empty;
                bus.door_lock  = !bus.water_empty;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wash_program_sequencer.sv
// Directed bench for wash_program_sequencer: state transitions are checked against a scoreboard of
// expected (state, dwell-in-previous-state) entries queued as each stimulus step is driven.
`timescale 1ns/1ps
module tb_wash_program_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    wash_program_sequencer_if wif();

    wash_program_sequencer #(
        .CNT_W(8), .FILL_TIMEOUT(8), .DET_CYCLES(2), .WASH_CYCLES(4),
        .DRAIN_TIMEOUT(8), .SPIN_CYCLES(3), .RINSES(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (wif.slave)
    );

    typedef struct {
        logic [3:0] code;
        int         plen;
    } tr_t;

    tr_t        exp_q[$];
    int         checks = 0;
    int         failures = 0;
    logic [3:0] last_state = 4'd0;
    int         dwell = 0;

    // {door_lock, fill_valve, detergent_valve, drain_pump, motor_on, spin_hi, done, fault}
    function automatic logic [7:0] outs();
        return {wif.door_lock, wif.fill_valve, wif.detergent_valve, wif.drain_pump,
                wif.motor_on, wif.spin_hi, wif.done, wif.fault};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic expect_tr(input logic [3:0] c, input int plen);
        tr_t e;
        e.code = c;
        e.plen = plen;
        exp_q.push_back(e);
    endtask

    task automatic step();
        tr_t e;
        @(posedge clk);
        #1;
        dwell++;
        if (wif.state !== last_state) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_transition", 32'(wif.state), 32'(last_state));
            end else begin
                e = exp_q.pop_front();
                chk("tr_state", 32'(wif.state), 32'(e.code));
                if (e.plen != 0) chk("tr_dwell", 32'(dwell), 32'(e.plen));
            end
            last_state = wif.state;
            dwell = 0;
        end
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic sb_drained(input string tag);
        chk(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Drive from IDLE into the first WASH cycle; water present, detergent pass.
    task automatic to_wash();
        wif.door_close = 1'b1; wif.water_empty = 1'b1; wif.water_full = 1'b0;
        wif.start = 1'b1;
        expect_tr(4'd1, 0); step();
        expect_tr(4'd2, 1); step();
        wif.start = 1'b0; wif.water_empty = 1'b0; wif.water_full = 1'b1;
        expect_tr(4'd3, 1); step();
        expect_tr(4'd4, 2); step_n(2);
    endtask

    task automatic full_run(input bit reset_in_spin);
        wif.door_close = 1'b1; wif.water_empty = 1'b1; wif.water_full = 1'b0;
        wif.start = 1'b1;
        expect_tr(4'd1, 0); step();
        chk("lock_outs", 32'(outs()), 32'h80);
        expect_tr(4'd2, 1); step();
        chk("fill_outs", 32'(outs()), 32'hC0);
        wif.water_empty = 1'b0;
        step();
        wif.water_full = 1'b1;
        expect_tr(4'd3, 2); step();
        chk("det_outs", 32'(outs()), 32'hA0);
        expect_tr(4'd4, 2); step_n(2);
        chk("wash_outs", 32'(outs()), 32'h88);
        wif.water_full = 1'b0;
        expect_tr(4'd5, 4); step_n(4);
        chk("drain_outs", 32'(outs()), 32'h90);
        step();
        wif.water_empty = 1'b1;
        expect_tr(4'd2, 2); step();
        wif.water_empty = 1'b0;
        step();
        wif.water_full = 1'b1;
        expect_tr(4'd4, 2); step();
        wif.water_full = 1'b0;
        expect_tr(4'd5, 4); step_n(4);
        step();
        wif.water_empty = 1'b1;
        expect_tr(4'd6, 2); step();
        chk("spin_outs", 32'(outs()), 32'h9C);
        if (reset_in_spin) begin
            step();
            #2 reset = 1'b0;
            #1;
            chk("async_rst_state", 32'(wif.state), 32'd0);
            chk("async_rst_outs", 32'(outs()), 32'h00);
            exp_q.delete();
            last_state = 4'd0; dwell = 0;
            wif.start = 1'b0;
            @(negedge clk);
            reset = 1'b1;
            step();
            chk("post_rst_idle", 32'(wif.state), 32'd0);
        end else begin
            expect_tr(4'd7, 3); step_n(3);
            chk("done_outs", 32'(outs()), 32'h02);
            step_n(3);
            chk("done_held_start", 32'(wif.state), 32'd7);
            wif.start = 1'b0;
            expect_tr(4'd0, 0); step();
            chk("idle_outs", 32'(outs()), 32'h00);
        end
        sb_drained("full_run_sb");
    endtask

    initial begin
        wif.start = 1'b0; wif.abort = 1'b0; wif.door_close = 1'b1;
        wif.water_full = 1'b0; wif.water_empty = 1'b1;
        #1;
        chk("reset_state", 32'(wif.state), 32'd0);
        chk("reset_outs", 32'(outs()), 32'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        last_state = 4'd0; dwell = 0;

        // Full program with one rinse pass.
        full_run(1'b0);

        // Fill timeout -> FAULT, drain/lock follow water, abort clears.
        wif.water_empty = 1'b0;
        wif.start = 1'b1;
        expect_tr(4'd1, 0); step();
        expect_tr(4'd2, 1); step();
        wif.start = 1'b0;
        expect_tr(4'd8, 8); step_n(8);
        chk("fill_to_outs", 32'(outs()), 32'h91);
        wif.water_empty = 1'b1;
        #1;
        chk("fault_empty_outs", 32'(outs()), 32'h01);
        wif.abort = 1'b1;
        expect_tr(4'd0, 0); step();
        wif.abort = 1'b0;
        chk("fault_clear_outs", 32'(outs()), 32'h00);
        sb_drained("fill_to_sb");

        // water_full on the last allowed FILL cycle wins over the timeout.
        wif.start = 1'b1; wif.water_full = 1'b0;
        expect_tr(4'd1, 0); step();
        expect_tr(4'd2, 1); step();
        wif.start = 1'b0; wif.water_empty = 1'b0;
        step_n(7);
        wif.water_full = 1'b1;
        expect_tr(4'd3, 8); step();
        wif.abort = 1'b1;
        expect_tr(4'd9, 1); step();
        wif.abort = 1'b0; wif.water_empty = 1'b1; wif.water_full = 1'b0;
        expect_tr(4'd0, 1); step();
        sb_drained("full_vs_to_sb");

        // Door opened during the second WASH cycle.
        to_wash();
        step();
        wif.door_close = 1'b0;
        expect_tr(4'd8, 2); step();
        chk("door_fault_outs", 32'(outs()), 32'h91);
        wif.door_close = 1'b1; wif.water_empty = 1'b1; wif.water_full = 1'b0;
        wif.abort = 1'b1;
        expect_tr(4'd0, 0); step();
        wif.abort = 1'b0;
        sb_drained("door_sb");

        // Abort during WASH with water in the drum.
        to_wash();
        step();
        wif.water_full = 1'b0;
        wif.abort = 1'b1;
        expect_tr(4'd9, 2); step();
        wif.abort = 1'b0;
        chk("abort_drain_outs", 32'(outs()), 32'h90);
        step();
        wif.water_empty = 1'b1;
        expect_tr(4'd0, 2); step();
        chk("abort_idle_outs", 32'(outs()), 32'h00);
        sb_drained("abort_sb");

        // start with the door open is ignored.
        wif.door_close = 1'b0; wif.start = 1'b1;
        step_n(3);
        chk("no_door_idle", 32'(wif.state), 32'd0);
        wif.start = 1'b0; wif.door_close = 1'b1;
        step();

        // Asynchronous reset in the middle of SPIN.
        full_run(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
